// File: rtl/regfile_mp.sv
// regfile_mp: parametrised 2-read / 2-write general-purpose register file.
//
// After reset a clear sequencer writes INIT_VAL into every entry, one per
// cycle. It then raises `ready` and the read and write ports go live.
//
// Ports
//   clk                      clock, all logic on posedge
//   reset                    synchronous, active-high reset
//   ready                    high once the clear walk has finished
//   readEnN / readAddrN      read port N request (N = 0, 1)
//   readDataN                read port N data, registered (1-cycle latency)
//   writeEnN / writeAddrN /
//   writeDataN               write port N request (N = 0, 1); port 1 wins
//                            when both ports write the same address
module regfile_mp #(
  parameter int                DATA_W   = 64,
  parameter int                ADDR_W   = 5,
  parameter bit                BYPASS   = 1'b1,
  parameter bit                ZERO_REG = 1'b0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ready,
  input  logic              readEn0,
  input  logic [ADDR_W-1:0] readAddr0,
  output logic [DATA_W-1:0] readData0,
  input  logic              readEn1,
  input  logic [ADDR_W-1:0] readAddr1,
  output logic [DATA_W-1:0] readData1,
  input  logic              writeEn0,
  input  logic [ADDR_W-1:0] writeAddr0,
  input  logic [DATA_W-1:0] writeData0,
  input  logic              writeEn1,
  input  logic [ADDR_W-1:0] writeAddr1,
  input  logic [DATA_W-1:0] writeData1
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clearPtr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              doWrite0;
  logic              doWrite1;
  logic [DATA_W-1:0] readNext0;
  logic [DATA_W-1:0] readNext1;

  // Read value for one port. The priority order is: hard-wired zero, then
  // port 1 bypass, then port 0 bypass, then the array. Checking port 1
  // before port 0 keeps the bypassed value equal to the value the array
  // will hold after a same-address collision.
  function automatic logic [DATA_W-1:0] selectRead(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] arrayVal,
    input logic              we0,
    input logic [ADDR_W-1:0] wa0,
    input logic [DATA_W-1:0] wd0,
    input logic              we1,
    input logic [ADDR_W-1:0] wa1,
    input logic [DATA_W-1:0] wd1
  );
    logic [DATA_W-1:0] result;
    result = arrayVal;
    if (ZERO_REG && addr == '0)
      result = '0;
    else if (BYPASS && we1 && wa1 == addr)
      result = wd1;
    else if (BYPASS && we0 && wa0 == addr)
      result = wd0;
    return result;
  endfunction

  always_comb begin
    // With ZERO_REG set, entry 0 is never written after the clear walk.
    doWrite0  = writeEn0 && !(ZERO_REG && writeAddr0 == '0);
    doWrite1  = writeEn1 && !(ZERO_REG && writeAddr1 == '0);
    readNext0 = selectRead(readAddr0, mem[readAddr0],
                           writeEn0, writeAddr0, writeData0,
                           writeEn1, writeAddr1, writeData1);
    readNext1 = selectRead(readAddr1, mem[readAddr1],
                           writeEn0, writeAddr0, writeData0,
                           writeEn1, writeAddr1, writeData1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // The array is left untouched here; the clear walk rewrites it.
      state     <= CLEAR;
      clearPtr  <= '0;
      ready     <= 1'b0;
      readData0 <= '0;
      readData1 <= '0;
    end else if (state == CLEAR) begin
      // In CLEAR the ports are ignored and readData holds its reset value 0.
      mem[clearPtr] <= INIT_VAL;
      clearPtr      <= clearPtr + ADDR_W'(1);
      if (clearPtr == ADDR_W'(DEPTH - 1)) begin
        state <= RUN;
        ready <= 1'b1;
      end
    end else begin
      // Port 1 is assigned last, so it wins a same-address collision.
      if (doWrite0)
        mem[writeAddr0] <= writeData0;
      if (doWrite1)
        mem[writeAddr1] <= writeData1;
      if (readEn0)
        readData0 <= readNext0;
      if (readEn1)
        readData1 <= readNext1;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp.
//
// The same stimulus drives three instances:
//   dutA - BYPASS=1, ZERO_REG=0
//   dutB - BYPASS=0, ZERO_REG=0
//   dutZ - BYPASS=1, ZERO_REG=1
// All three use the same INIT_VAL. The stimulus pushes hand-computed
// expected values for each instance into a queue per read port. A monitor
// pops an entry and compares it whenever a read result is due.
module tb_regfile_mp;

  localparam logic [63:0] INIT = 64'hDEAD_BEEF_0000_0001;

  logic        clk;
  logic        reset;
  logic        readEn0, readEn1, writeEn0, writeEn1;
  logic [4:0]  readAddr0, readAddr1, writeAddr0, writeAddr1;
  logic [63:0] writeData0, writeData1;

  logic        readyA, readyB, readyZ;
  logic [63:0] rdA0, rdA1, rdB0, rdB1, rdZ0, rdZ1;

  typedef struct {
    string       tag;
    logic [63:0] eA;
    logic [63:0] eB;
    logic [63:0] eZ;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  int   nChecks = 0;
  int   nPass   = 0;
  logic vld0    = 1'b0;
  logic vld1    = 1'b0;

  regfile_mp #(.DATA_W(64), .ADDR_W(5), .BYPASS(1'b1), .ZERO_REG(1'b0), .INIT_VAL(INIT)) dutA (
    .clk(clk), .reset(reset), .ready(readyA),
    .readEn0(readEn0), .readAddr0(readAddr0), .readData0(rdA0),
    .readEn1(readEn1), .readAddr1(readAddr1), .readData1(rdA1),
    .writeEn0(writeEn0), .writeAddr0(writeAddr0), .writeData0(writeData0),
    .writeEn1(writeEn1), .writeAddr1(writeAddr1), .writeData1(writeData1));

  regfile_mp #(.DATA_W(64), .ADDR_W(5), .BYPASS(1'b0), .ZERO_REG(1'b0), .INIT_VAL(INIT)) dutB (
    .clk(clk), .reset(reset), .ready(readyB),
    .readEn0(readEn0), .readAddr0(readAddr0), .readData0(rdB0),
    .readEn1(readEn1), .readAddr1(readAddr1), .readData1(rdB1),
    .writeEn0(writeEn0), .writeAddr0(writeAddr0), .writeData0(writeData0),
    .writeEn1(writeEn1), .writeAddr1(writeAddr1), .writeData1(writeData1));

  regfile_mp #(.DATA_W(64), .ADDR_W(5), .BYPASS(1'b1), .ZERO_REG(1'b1), .INIT_VAL(INIT)) dutZ (
    .clk(clk), .reset(reset), .ready(readyZ),
    .readEn0(readEn0), .readAddr0(readAddr0), .readData0(rdZ0),
    .readEn1(readEn1), .readAddr1(readAddr1), .readData1(rdZ1),
    .writeEn0(writeEn0), .writeAddr0(writeAddr0), .writeData0(writeData0),
    .writeEn1(writeEn1), .writeAddr1(writeAddr1), .writeData1(writeData1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h, expected %h", tag, act, exp);
  endtask

  // A read result is due one edge after an accepted read request.
  always @(posedge clk) begin
    vld0 <= readEn0 && readyA && !reset;
    vld1 <= readEn1 && readyA && !reset;
  end

  always @(negedge clk) begin
    exp_t e;
    if (vld0) begin
      if (sb0.size() == 0) chk("sb0 underflow", 64'd1, 64'd0);
      else begin
        e = sb0.pop_front();
        chk({e.tag, " p0 dutA"}, rdA0, e.eA);
        chk({e.tag, " p0 dutB"}, rdB0, e.eB);
        chk({e.tag, " p0 dutZ"}, rdZ0, e.eZ);
      end
    end
    if (vld1) begin
      if (sb1.size() == 0) chk("sb1 underflow", 64'd1, 64'd0);
      else begin
        e = sb1.pop_front();
        chk({e.tag, " p1 dutA"}, rdA1, e.eA);
        chk({e.tag, " p1 dutB"}, rdB1, e.eB);
        chk({e.tag, " p1 dutZ"}, rdZ1, e.eZ);
      end
    end
  end

  task automatic push(input int port, input string tag,
                      input logic [63:0] eA, input logic [63:0] eB, input logic [63:0] eZ);
    exp_t e;
    e.tag = tag; e.eA = eA; e.eB = eB; e.eZ = eZ;
    if (port == 0) sb0.push_back(e);
    else           sb1.push_back(e);
  endtask

  task automatic idle();
    readEn0 = 1'b0; readEn1 = 1'b0; writeEn0 = 1'b0; writeEn1 = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic rd(input int port, input logic [4:0] addr);
    if (port == 0) begin readEn0 = 1'b1; readAddr0 = addr; end
    else           begin readEn1 = 1'b1; readAddr1 = addr; end
  endtask

  task automatic wr(input int port, input logic [4:0] addr, input logic [63:0] data);
    if (port == 0) begin writeEn0 = 1'b1; writeAddr0 = addr; writeData0 = data; end
    else           begin writeEn1 = 1'b1; writeAddr1 = addr; writeData1 = data; end
  endtask

  // Called right after the last reset cycle. The n-th step is the n-th
  // posedge with reset low, and ready must first read 1 at n = 32.
  task automatic waitClear();
    for (int i = 1; i <= 32; i++) begin
      step();
      chk($sformatf("readyA c%0d", i), {63'd0, readyA}, {63'd0, i == 32});
      chk($sformatf("readyB c%0d", i), {63'd0, readyB}, {63'd0, i == 32});
      chk($sformatf("readyZ c%0d", i), {63'd0, readyZ}, {63'd0, i == 32});
      if (i == 16) chk("clearHold rdA0", rdA0, 64'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    readAddr0 = '0; readAddr1 = '0; writeAddr0 = '0; writeAddr1 = '0;
    writeData0 = '0; writeData1 = '0;
    idle();
    step(); step();
    chk("rst readyA", {63'd0, readyA}, 64'd0);
    chk("rst rdA0", rdA0, 64'd0);
    chk("rst rdZ1", rdZ1, 64'd0);

    // Clear walk, with a read request held during it that must be ignored.
    reset = 1'b0;
    rd(0, 5'd5);
    waitClear();
    idle();

    // Every entry holds INIT_VAL; dutZ returns 0 for entry 0.
    for (int i = 0; i < 32; i++) begin
      rd(0, 5'(i));
      rd(1, 5'(31 - i));
      push(0, $sformatf("init a%0d", i), INIT, INIT, (i == 0) ? 64'd0 : INIT);
      push(1, $sformatf("init a%0d", 31 - i), INIT, INIT, (i == 31) ? 64'd0 : INIT);
      step();
    end
    idle();

    // Basic write, then read, then hold.
    wr(0, 5'd5, 64'h1234); step(); idle();
    rd(1, 5'd5); push(1, "basic", 64'h1234, 64'h1234, 64'h1234); step(); idle();
    step(); step();
    chk("hold rdA1", rdA1, 64'h1234);
    chk("hold rdB1", rdB1, 64'h1234);

    // Same-cycle write/read of addr 7.
    wr(0, 5'd7, 64'hA); step(); idle();
    wr(0, 5'd7, 64'hB); rd(0, 5'd7); push(0, "bypass", 64'hB, 64'hA, 64'hB); step(); idle();
    rd(0, 5'd7); push(0, "bypassNext", 64'hB, 64'hB, 64'hB); step(); idle();

    // Same-address collision; port 1 wins in the array and in the bypass.
    wr(0, 5'd9, 64'h111); wr(1, 5'd9, 64'h222); rd(0, 5'd9); rd(1, 5'd9);
    push(0, "collide", 64'h222, INIT, 64'h222);
    push(1, "collide", 64'h222, INIT, 64'h222);
    step(); idle();
    rd(0, 5'd9); push(0, "collideRd", 64'h222, 64'h222, 64'h222); step(); idle();

    // Each bypass source selected by address.
    wr(0, 5'd10, 64'h333); wr(1, 5'd11, 64'h444); rd(0, 5'd10); rd(1, 5'd11);
    push(0, "split", 64'h333, INIT, 64'h333);
    push(1, "split", 64'h444, INIT, 64'h444);
    step(); idle();

    // Writes to entry 0 on both ports.
    wr(0, 5'd0, 64'hFFFF); wr(1, 5'd0, 64'hFFFF); rd(0, 5'd0); rd(1, 5'd1);
    push(0, "zeroByp", 64'hFFFF, INIT, 64'd0);
    push(1, "zeroAddr1", INIT, INIT, INIT);
    step(); idle();
    rd(0, 5'd0); rd(1, 5'd1);
    push(0, "zeroRd", 64'hFFFF, 64'hFFFF, 64'd0);
    push(1, "zeroRdA1", INIT, INIT, INIT);
    step(); idle();

    // Reset mid-operation with writes held during the clear walk.
    wr(0, 5'd3, 64'h55); step(); idle();
    rd(0, 5'd3); push(0, "pre55", 64'h55, 64'h55, 64'h55); step(); idle();
    step();
    reset = 1'b1; step();
    chk("rst2 rdA0", rdA0, 64'd0);
    chk("rst2 readyA", {63'd0, readyA}, 64'd0);
    reset = 1'b0;
    wr(0, 5'd3, 64'h99); wr(1, 5'd20, 64'h77);
    repeat (10) step();
    reset = 1'b1; step();
    chk("rst3 readyA", {63'd0, readyA}, 64'd0);
    reset = 1'b0;
    waitClear();
    idle();
    rd(0, 5'd3); rd(1, 5'd20);
    push(0, "postClr a3", INIT, INIT, INIT);
    push(1, "postClr a20", INIT, INIT, INIT);
    step(); idle();

    step(); step();
    chk("sb0 drained", 64'(sb0.size()), 64'd0);
    chk("sb1 drained", 64'(sb1.size()), 64'd0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", nChecks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the core's 2R/2W general-purpose register file.
- Configurable data width and address width.
- Optional write-to-read bypass and optional hard-wired zero entry.
- Hardware clear sequencer: after reset, every entry is walked to a known value before `ready` asserts. No file-based preload is used.
- Sits between decode (read ports) and writeback (write ports); issue logic stalls on `ready` low.

Parameters:
- DATA_W, 64, width of each register entry.
- ADDR_W, 5, address width; depth DEPTH = 2**ADDR_W (derived, not overridable).
- BYPASS, 1, 1 = a read in the same cycle as a write to the same address returns the new data; 0 = returns the old (pre-write) data.
- ZERO_REG, 0, 1 = entry 0 always reads as 0 and writes to it are dropped.
- INIT_VAL, 0, DATA_W-bit value written to every entry by the clear sequencer.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- ready  out  1  high when clear is done and ports are live.
- readEn0  in  1  read port 0 enable.
- readAddr0  in  ADDR_W  read port 0 address.
- readData0  out  DATA_W  read port 0 data, registered.
- readEn1  in  1  read port 1 enable.
- readAddr1  in  ADDR_W  read port 1 address.
- readData1  out  DATA_W  read port 1 data, registered.
- writeEn0  in  1  write port 0 enable.
- writeAddr0  in  ADDR_W  write port 0 address.
- writeData0  in  DATA_W  write port 0 data.
- writeEn1  in  1  write port 1 enable.
- writeAddr1  in  ADDR_W  write port 1 address.
- writeData1  in  DATA_W  write port 1 data.

Behaviour:
- One clock `clk`; reset `reset` is synchronous and active-high.
- Reset (cycle where reset=1 at posedge):
  - readData0 = readData1 = 0, ready = 0.
  - State := CLEAR, clear pointer := 0.
  - Array contents are not touched in the reset cycle itself.
- State machine, two states:
  - CLEAR: each cycle, mem[ptr] := INIT_VAL and ptr := ptr+1. When ptr == DEPTH-1 is written, next state is RUN.
  - RUN: terminal until the next reset.
  - ready is registered and equals (state == RUN). It first reads 1 exactly DEPTH cycles after the first posedge with reset=0 (32 cycles at default).
- Reset asserted mid-CLEAR or in RUN: restart CLEAR at ptr 0. Partially cleared entries are re-cleared.
- During CLEAR:
  - All writeEn* are ignored.
  - readEn* are ignored; readData* hold 0.
  - No bypass occurs.
- Read latency in RUN: 1 cycle.
  - readDataN updates at the posedge where readEnN=1.
  - When readEnN=0, readDataN holds its previous value.
- Read value selection in RUN (in priority order):
  - ZERO_REG=1 and readAddrN==0 → 0.
  - Else BYPASS=1 and writeEn1 && writeAddr1==readAddrN → writeData1.
  - Else BYPASS=1 and writeEn0 && writeAddr0==readAddrN → writeData0.
  - Else mem[readAddrN] (value before this cycle's writes).
- Writes in RUN take effect at the posedge; visible to array reads from the next cycle.
- Same-address write collision (writeEn0 && writeEn1 && writeAddr0==writeAddr1): writeData1 is stored; port 1 wins. Bypass priority matches this.
- ZERO_REG=1: writes to address 0 are dropped on both ports; the collision rule is irrelevant there.
- Both read ports may hit the same address in the same cycle; both return the same value.
- No X propagation: every array entry is defined after CLEAR.
- No address range check is needed; the full 2**ADDR_W space is implemented.
- Implementation:
  - Array as registers (no readmem).
  - Single always block on posedge clk for state, pointer, array and read registers; next-value muxing may be combinational.

Test Plan:
- Reset/clear, default params, INIT_VAL=64'hDEAD_BEEF_0000_0001:
  - Hold reset 2 cycles, release → ready=0 for cycles 1..31 after release, ready=1 at cycle 32.
  - Then reading addr 0..31 returns INIT_VAL on each.
- Basic write/read:
  - writeEn0, addr 5, data 64'h1234 at cycle T; readEn1 addr 5 at T+1 → readData1 = 64'h1234 at T+2.
  - readData1 then holds with readEn1=0.
- Bypass:
  - BYPASS=1: mem[7]=0xA; same cycle writeEn0 addr 7 data 0xB and readEn0 addr 7 → readData0 = 0xB.
  - BYPASS=0, same stimulus → readData0 = 0xA; next-cycle read → 0xB.
- Write collision:
  - writeEn0 addr 9 data 0x111 and writeEn1 addr 9 data 0x222 in the same cycle → later read of 9 = 0x222.
  - BYPASS=1 same-cycle read of 9 → 0x222.
- ZERO_REG=1:
  - Write 0xFFFF to addr 0 on both ports; read addr 0 → 0, including a same-cycle bypass read.
  - Addr 1 unaffected.
- Reset mid-operation:
  - In RUN, write 0x55 to addr 3.
  - Assert reset at cycle 10 of a subsequent CLEAR, and also assert writeEn0 during CLEAR.
  - Required: ready stays 0 for 32 cycles after the final reset release; writes during CLEAR are dropped; addr 3 reads INIT_VAL afterwards.
